mem_responder: RTL



---
 rtl/mem_responder.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Purpose:
//   Memory-side responder for the RISC CPU load/store path. It accepts one read
//   or write request at a time. After a programmable wait it responds with a
//   one-cycle ready pulse. It serves a 256x16 data RAM plus two memory-mapped
//   I/O locations: an LED output register and a synchronised switch port.
//
// Address map (9-bit word address):
//   addr[8] = 0 : RAM word addr[7:0]
//   LED_ADDR    : LED register (write; read only with LED readback enabled)
//   SW_ADDR     : switch port (read only)
//   other I/O   : unmapped -> access dropped, err pulses with ready
//
// Ports:
//   clk     in   1   rising-edge clock
//   reset   in   1   synchronous, active-high reset
//   req     in   1   request strobe, sampled only while idle
//   mwrite  in   1   1 = write, 0 = read (qualified by req)
//   addr    in   9   word address
//   wdata   in  16   write data
//   busy    out  1   high whenever a transaction is in progress
//   ready   out  1   one-cycle response pulse
//   rdata   out 16   read data, valid with ready and held until next response
//   err     out  1   pulses with ready on an illegal/unmapped access
//   led     out 10   LED register
//   sw      in   8   asynchronous board switches
//
// Optional feature:
//   MEM_RESPONDER_LED_READBACK_EN - when defined, a read of LED_ADDR returns
//   {6'b0, led} with err=0. When undefined, it behaves like unmapped I/O.
//
// Timing:
//   A request accepted at edge N produces ready (and rdata/err/led/RAM update)
//   at edge N+1+WAIT_CYCLES. busy covers the WAIT and RESP states.
// -----------------------------------------------------------------------------
module mem_responder #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [8:0]  LED_ADDR    = 9'h100,
   parameter logic [8:0]  SW_ADDR     = 9'h140
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        mwrite,
   input  logic [8:0]  addr,
   input  logic [15:0] wdata,
   output logic        busy,
   output logic        ready,
   output logic [15:0] rdata,
   output logic        err,
   output logic [9:0]  led,
   input  logic [7:0]  sw
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // The counter is loaded with WAIT_CYCLES-1 so that the last WAIT cycle is
   // the one where the counter reads zero.
   localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        mwrite_q, mwrite_d;
   logic [8:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        busy_q, busy_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;
   logic [15:0] rdata_q, rdata_d;
   logic [9:0]  led_q, led_d;
   logic [7:0]  sw_meta_q, sw_meta_d;
   logic [7:0]  sw_sync_q, sw_sync_d;

   // Data RAM, no reset on contents. The read port is registered.
   logic [15:0] ram_mem [256];
   logic [15:0] ram_rd_q;
   logic        ram_we;
   logic [7:0]  ram_raddr;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mwrite_d  = mwrite_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      ready_d   = 1'b0;
      err_d     = 1'b0;
      rdata_d   = rdata_q;
      led_d     = led_q;
      sw_meta_d = sw;
      sw_sync_d = sw_meta_q;
      ram_we    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               mwrite_d = mwrite;
               addr_d   = addr;
               wdata_d  = wdata;
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end

         ST_WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
            if (!addr_q[8]) begin
               // RAM access. Writes commit at this edge. For reads, ram_rd_q
               // already holds the captured word because the read address
               // followed the captured address since acceptance.
               if (mwrite_q) begin
                  ram_we = ~reset;
               end else begin
                  rdata_d = ram_rd_q;
               end
            end else if (addr_q == LED_ADDR) begin
               if (mwrite_q) begin
                  led_d = wdata_q[9:0];
               end else begin
`ifdef MEM_RESPONDER_LED_READBACK_EN
                  rdata_d = {6'b0, led_q};
`else
                  rdata_d = 16'h0000;
                  err_d   = 1'b1;
`endif
               end
            end else if (addr_q == SW_ADDR) begin
               if (mwrite_q) begin
                  err_d = 1'b1;
               end else begin
                  rdata_d = {8'h00, sw_sync_q};
               end
            end else begin
               // Unmapped I/O: writes are dropped, reads return zero.
               err_d = 1'b1;
               if (!mwrite_q) begin
                  rdata_d = 16'h0000;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // The read address follows the next captured address. The registered read
   // then always reflects the word addressed by the pending transaction.
   assign ram_raddr = addr_d[7:0];

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 3'd0;
         mwrite_q  <= 1'b0;
         addr_q    <= 9'h000;
         wdata_q   <= 16'h0000;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= 16'h0000;
         led_q     <= 10'h000;
         sw_meta_q <= 8'h00;
         sw_sync_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mwrite_q  <= mwrite_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         led_q     <= led_d;
         sw_meta_q <= sw_meta_d;
         sw_sync_q <= sw_sync_d;
      end
   end

   // -------------------------------------------------------------------------
   // Data RAM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_mem[addr_q[7:0]] <= wdata_q;
      end
      ram_rd_q <= ram_mem[ram_raddr];
   end

   assign busy  = busy_q;
   assign ready = ready_q;
   assign err   = err_q;
   assign rdata = rdata_q;
   assign led   = led_q;

endmodule
